// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared timing helpers for the multi-channel debouncer
package debounce_pkg;

  localparam int REPEAT_TIME_MS = 100;

  // Ceiling of ms * 1e6 / clk_period_ns; 64-bit intermediate keeps long hold times exact.
  function automatic int ms_to_cycles(input int ms, input int clk_period_ns);
    longint num;
    num = longint'(ms) * 64'sd1000000 + longint'(clk_period_ns) - 64'sd1;
    return int'(num / longint'(clk_period_ns));
  endfunction

  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one input channel: synchroniser, stability counter, edge and hold strobes
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int HOLD_CYCLES     = 20,
  parameter bit AUTO_REPEAT     = 1'b0,
  parameter int REPEAT_CYCLES   = 5
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic dirty_in,
  output logic clean_out,
  output logic rise_out,
  output logic fall_out,
  output logic hold_out
);

  localparam int HOLD_MAX = AUTO_REPEAT ? HOLD_CYCLES + REPEAT_CYCLES - 1 : HOLD_CYCLES;
  localparam int DW       = cnt_width(DEBOUNCE_CYCLES - 1);
  localparam int HW       = cnt_width(HOLD_MAX);

  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_FIRST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_AT    = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] REP_LAST   = HW'(HOLD_MAX);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_prev_q;
  logic [DW-1:0]          db_cnt_q;
  logic [HW-1:0]          hold_cnt_q;
  logic                   clean_q, rise_q, fall_q, hold_q;
  logic                   s, settle, rise_d, fall_d;

  assign s      = sync_q[SYNC_STAGES-1];
  assign settle = (s == s_prev_q) && (db_cnt_q == DB_LAST);
  assign rise_d = settle && s && !clean_q;
  assign fall_d = settle && !s && clean_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sync_q     <= '0;
      s_prev_q   <= 1'b0;
      db_cnt_q   <= '0;
      hold_cnt_q <= '0;
      clean_q    <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      hold_q     <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], dirty_in};
      s_prev_q <= s;
      if (s != s_prev_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q != DB_LAST) begin
        db_cnt_q <= db_cnt_q + 1'b1;
      end
      if (settle) begin
        clean_q <= s;
      end
      rise_q <= rise_d;
      fall_q <= fall_d;

      // Repeat phase cycles HOLD_AT..REP_LAST; a release on the boundary suppresses the strobe.
      hold_q <= 1'b0;
      if (!clean_q || fall_d) begin
        hold_cnt_q <= '0;
      end else if (hold_cnt_q == HOLD_FIRST || (AUTO_REPEAT && hold_cnt_q == REP_LAST)) begin
        hold_cnt_q <= HOLD_AT;
        hold_q     <= 1'b1;
      end else if (AUTO_REPEAT || hold_cnt_q != HOLD_AT) begin
        hold_cnt_q <= hold_cnt_q + 1'b1;
      end
    end
  end

  assign clean_out = clean_q;
  assign rise_out  = rise_q;
  assign fall_out  = fall_q;
  assign hold_out  = hold_q;

endmodule

// File: rtl/multi_debouncer.sv
// rtl/multi_debouncer.sv - NUM_CH independent debounce channels with edge and long-press strobes
module multi_debouncer
  import debounce_pkg::*;
#(
  parameter int NUM_CH           = 4,
  parameter int CLK_PERIOD_NS    = 10,
  parameter int DEBOUNCE_TIME_MS = 5,
  parameter int DEBOUNCE_CYCLES  = ms_to_cycles(DEBOUNCE_TIME_MS, CLK_PERIOD_NS),
  parameter int SYNC_STAGES      = 2,
  parameter int HOLD_TIME_MS     = 1000,
  parameter int HOLD_CYCLES      = ms_to_cycles(HOLD_TIME_MS, CLK_PERIOD_NS),
  parameter bit AUTO_REPEAT      = 1'b0,
  parameter int REPEAT_CYCLES    = ms_to_cycles(REPEAT_TIME_MS, CLK_PERIOD_NS)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [NUM_CH-1:0] dirty_in,
  output logic [NUM_CH-1:0] clean_out,
  output logic [NUM_CH-1:0] rise_out,
  output logic [NUM_CH-1:0] fall_out,
  output logic [NUM_CH-1:0] hold_out
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES),
      .AUTO_REPEAT    (AUTO_REPEAT),
      .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_ch (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .dirty_in (dirty_in[i]),
      .clean_out(clean_out[i]),
      .rise_out (rise_out[i]),
      .fall_out (fall_out[i]),
      .hold_out (hold_out[i])
    );
  end

endmodule

// File: tb/tb_multi_debouncer.sv
// tb/tb_multi_debouncer.sv - scoreboard bench for multi_debouncer, one-shot and auto-repeat instances
module tb_multi_debouncer;

  typedef struct {
    int         cyc;
    logic [3:0] clean;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] hold;
  } ev_t;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic [3:0] dirty_in;
  logic [3:0] clean0, rise0, fall0, hold0;
  logic [3:0] clean1, rise1, fall1, hold1;

  int   cyc      = 0;
  logic rst_seen = 1'b0;
  int   checks   = 0;
  int   errors   = 0;
  ev_t  q0[$];
  ev_t  q1[$];
  logic [3:0] exp_cl [2];

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    cyc      <= cyc + 1;
    rst_seen <= rst_in;
  end

  multi_debouncer #(
    .NUM_CH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8), .HOLD_CYCLES(20),
    .AUTO_REPEAT(1'b0), .REPEAT_CYCLES(5)
  ) dut_once (
    .clk_in(clk_in), .rst_in(rst_in), .dirty_in(dirty_in),
    .clean_out(clean0), .rise_out(rise0), .fall_out(fall0), .hold_out(hold0)
  );

  multi_debouncer #(
    .NUM_CH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8), .HOLD_CYCLES(20),
    .AUTO_REPEAT(1'b1), .REPEAT_CYCLES(5)
  ) dut_rep (
    .clk_in(clk_in), .rst_in(rst_in), .dirty_in(dirty_in),
    .clean_out(clean1), .rise_out(rise1), .fall_out(fall1), .hold_out(hold1)
  );

  task automatic push(input int c, input logic [3:0] cl, input logic [3:0] ri,
                      input logic [3:0] fa, input logic [3:0] h0, input logic [3:0] h1);
    ev_t e;
    e.cyc = c; e.clean = cl; e.rise = ri; e.fall = fa; e.hold = 4'b0;
    if ((ri | fa | h0) != 4'b0) begin e.hold = h0; q0.push_back(e); end
    if ((ri | fa | h1) != 4'b0) begin e.hold = h1; q1.push_back(e); end
  endtask

  // Rise at r, release at f: one hold at r+20, repeats every 5 after that, none on the release cycle.
  task automatic press(input int r, input int f, input logic [3:0] m);
    push(r, m, m, 4'b0, 4'b0, 4'b0);
    for (int t = r + 20; t < f; t += 5)
      push(t, m, 4'b0, 4'b0, (t == r + 20) ? m : 4'b0, m);
    push(f, 4'b0, 4'b0, m, 4'b0, 4'b0);
  endtask

  task automatic mon(input int k, input logic [3:0] cl, input logic [3:0] ri,
                     input logic [3:0] fa, input logic [3:0] ho);
    ev_t   e;
    bit    have;
    string nm;
    nm   = (k == 0) ? "once" : "rep";
    have = 1'b0;
    e    = '{cyc: 0, clean: 4'b0, rise: 4'b0, fall: 4'b0, hold: 4'b0};
    if (k == 0 && q0.size() > 0 && q0[0].cyc == cyc) begin e = q0.pop_front(); have = 1'b1; end
    if (k == 1 && q1.size() > 0 && q1[0].cyc == cyc) begin e = q1.pop_front(); have = 1'b1; end
    if (rst_seen) exp_cl[k] = 4'b0;
    else if (have) exp_cl[k] = e.clean;
    checks++;
    if (cl !== exp_cl[k]) begin
      errors++;
      $display("FAIL %s clean cyc=%0d got=%b exp=%b", nm, cyc, cl, exp_cl[k]);
    end
    if (have) begin
      checks++;
      if ({ri, fa, ho} !== {e.rise, e.fall, e.hold}) begin
        errors++;
        $display("FAIL %s strobes cyc=%0d got r=%b f=%b h=%b exp r=%b f=%b h=%b",
                 nm, cyc, ri, fa, ho, e.rise, e.fall, e.hold);
      end
    end else if ((ri | fa | ho) != 4'b0) begin
      checks++;
      errors++;
      $display("FAIL %s unexpected strobe cyc=%0d got r=%b f=%b h=%b exp none",
               nm, cyc, ri, fa, ho);
    end
  endtask

  always @(negedge clk_in) begin
    mon(0, clean0, rise0, fall0, hold0);
    mon(1, clean1, rise1, fall1, hold1);
  end

  task automatic wait_cyc(input int n);
    do @(negedge clk_in); while (cyc < n);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    rst_in    = 1'b1;
    dirty_in  = 4'b1111;
    exp_cl[0] = 4'b0;
    exp_cl[1] = 4'b0;

    // All channels high through reset: settle 11 edges after release (edge 4 is the first sample).
    press(14, 31, 4'b1111);
    wait_cyc(3);   rst_in = 1'b0;
    wait_cyc(20);  dirty_in = 4'b0000;

    press(51, 66, 4'b0001);
    wait_cyc(40);  dirty_in = 4'b0001;
    wait_cyc(55);  dirty_in = 4'b0000;

    // ch1 bounces 1,0,1 at 3-cycle spacing; only the final level counts.
    press(87, 101, 4'b0010);
    wait_cyc(70);  dirty_in = 4'b0010;
    wait_cyc(73);  dirty_in = 4'b0000;
    wait_cyc(76);  dirty_in = 4'b0010;
    wait_cyc(90);  dirty_in = 4'b0000;

    press(121, 163, 4'b0100);
    wait_cyc(110); dirty_in = 4'b0100;
    wait_cyc(152); dirty_in = 4'b0000;

    // ch3 release lands on the repeat boundary at 211.
    press(181, 211, 4'b1000);
    wait_cyc(170); dirty_in = 4'b1000;
    wait_cyc(200); dirty_in = 4'b0000;

    // Reset pulse at edge 244: ch0 stability count is 5, ch2 hold count is 12.
    push(231, 4'b0100, 4'b0100, 4'b0, 4'b0, 4'b0);
    wait_cyc(220); dirty_in = 4'b0100;
    wait_cyc(235); dirty_in = 4'b0101;
    wait_cyc(243); rst_in = 1'b1;
    press(255, 287, 4'b0101);
    wait_cyc(244); rst_in = 1'b0;
    wait_cyc(276); dirty_in = 4'b0000;

    wait_cyc(300);
    while (q0.size() > 0) begin
      ev_t e;
      e = q0.pop_front();
      checks++; errors++;
      $display("FAIL once missing event got=none exp cyc=%0d", e.cyc);
    end
    while (q1.size() > 0) begin
      ev_t e;
      e = q1.pop_front();
      checks++; errors++;
      $display("FAIL rep missing event got=none exp cyc=%0d", e.cyc);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
